mul1024_host_bridge: RTL and testbench
======================================

// Module: mul1024_host_bridge
// PURPOSE
//  Word-serial host front end for the 1024x1024 multiplier. Assembles both operands from 32-bit bus
//  writes, then drives the multiplier's enable/load handshake. Waits for the multiplier's data-valid
//  with a timeout, captures the 2048-bit product, and serves it back as 32-bit reads.
//  Sits between the HPS bus slave and the multiplier's iEnable/iLoad/iX/iY/oDataValid/oZ.
// PARAMETERS
//  WORD_W       32    bus word width
//  OP_W         1024  operand width (OP_W/WORD_W = 32 words, word index 5 bits)
//  RES_W        2048  product width (64 words, word index 6 bits)
//  TIMEOUT_CYC  8191  max WAIT cycles before error; must be < 65536 (16-bit counter)
// PORTS
//  iClk           in   1      clock; all logic on rising edge
//  iRstn          in   1      reset, synchronous, active-low
//  iWrite         in   1      operand word write strobe
//  iWrSel         in   1      0 = X operand, 1 = Y operand
//  iWrAddr        in   5      operand word index; word k = bits [32k+31:32k]
//  iWrData        in   32     operand word
//  iStart         in   1      start multiply (single-cycle pulse expected)
//  iRead          in   1      result read strobe
//  iRdAddr        in   6      result word index
//  oRdData        out  32     registered read data
//  oBusy          out  1      1 in LOAD/WAIT
//  oDone          out  1      1 in DONE
//  oError         out  1      1 if last operation timed out
//  oMulEnable     out  1      to multiplier iEnable
//  oMulLoad       out  1      to multiplier iLoad
//  oMulX, oMulY   out  1024   operand registers, to multiplier iX/iY
//  iMulDataValid  in   1      from multiplier oDataValid
//  iMulZ          in   2048   from multiplier oZ
// BEHAVIOUR
//  - Reset (iRstn=0 at edge): state IDLE; all outputs 0; operand, result and counter registers 0.
//    Applies mid-operation; oMulEnable is 0 the cycle after the reset edge.
//  - FSM states: IDLE, LOAD, WAIT, DONE.
//    IDLE/DONE --iStart--> LOAD. LOAD --> WAIT unconditionally.
//    WAIT --iMulDataValid--> DONE (capture). WAIT --counter==TIMEOUT_CYC--> DONE (error).
//    DONE persists until the next iStart.
//  - Writes are accepted only in IDLE/DONE and update the addressed word on the edge. They are ignored in LOAD/WAIT.
//  - Simultaneous iWrite+iStart in IDLE/DONE: the write lands, and the load uses the updated operand.
//  - iStart in LOAD/WAIT: ignored.
//  - LOAD (1 cycle): oMulEnable=1, oMulLoad=1, oBusy=1; oDone, oError cleared; counter cleared.
//  - WAIT: oMulEnable=1, oMulLoad=0, oBusy=1; counter +1 per WAIT cycle.
//  - Capture: on the first WAIT cycle with iMulDataValid=1, iMulZ is registered into the result register.
//    Next cycle: DONE, oMulEnable=0, oBusy=0, oDone=1, oError=0.
//  - Timeout: after TIMEOUT_CYC WAIT cycles without valid, go to DONE with oError=1, result register
//    zeroed and oMulEnable=0. A valid arriving in the same cycle as the limit wins: capture, no error.
//  - iMulDataValid outside WAIT (including LOAD) is ignored.
//  - oMulEnable is 0 in IDLE/DONE. A new operation therefore always sees enable low for >=1 cycle
//    before the load, which clears the multiplier's sign state.
//  - Reads: 1-cycle latency. iRead at edge n gives oRdData = result[32k+31:32k] after edge n, k=iRdAddr.
//    Reads in LOAD/WAIT return 0. oRdData holds its value while iRead=0.
//  - oMulX/oMulY are driven directly from the operand registers and change only on accepted writes.
// TESTING
//  1. X word0=3, Y word0=5, other words 0, iStart -> oMulLoad high exactly 1 cycle after start,
//     oMulX[31:0]=3. Model returns iMulZ=15 after 100 cycles -> oDone=1; read 0 -> 15, read 1 -> 0.
//  2. Write all 32 X words with 0xFFFFFFFF and Y word k=k -> oMulX all ones, oMulY[32k+:32]=k.
//     Model returns iMulZ word k=0xA5000000+k -> reads 0..63 match word for word.
//  3. TIMEOUT_CYC=200, no valid -> oError=1, oDone=1 exactly 201 cycles after LOAD; reads return 0.
//     Valid at exactly the limit cycle -> oError=0, product captured.
//  4. iWrite and iStart during WAIT -> operands unchanged, no second load. iWrite(X word0=7)+iStart in
//     the same IDLE cycle -> oMulX[31:0]=7 at the load cycle.
//  5. iRstn=0 mid-WAIT -> next cycle all outputs 0, state IDLE; a following start completes normally.
//  6. iMulDataValid=1 during LOAD, then 0 for 50 WAIT cycles, then 1 -> only the later iMulZ captured.

Source files
------------

// File: rtl/mul1024_host_bridge_if.sv
// mul1024_host_bridge_if: host word bus plus multiplier handshake around the bridge
interface mul1024_host_bridge_if #(parameter int WORD_W = 32, parameter int OP_W = 1024, parameter int RES_W = 2048);
  localparam int OPA = $clog2(OP_W / WORD_W);
  localparam int RSA = $clog2(RES_W / WORD_W);
  logic              iWrite;
  logic              iWrSel;
  logic [OPA-1:0]    iWrAddr;
  logic [WORD_W-1:0] iWrData;
  logic              iStart;
  logic              iRead;
  logic [RSA-1:0]    iRdAddr;
  logic [WORD_W-1:0] oRdData;
  logic              oBusy;
  logic              oDone;
  logic              oError;
  logic              oMulEnable;
  logic              oMulLoad;
  logic [OP_W-1:0]   oMulX;
  logic [OP_W-1:0]   oMulY;
  logic              iMulDataValid;
  logic [RES_W-1:0]  iMulZ;
  modport slave (
    input  iWrite, iWrSel, iWrAddr, iWrData, iStart, iRead, iRdAddr, iMulDataValid, iMulZ,
    output oRdData, oBusy, oDone, oError, oMulEnable, oMulLoad, oMulX, oMulY
  );
  modport master (
    output iWrite, iWrSel, iWrAddr, iWrData, iStart, iRead, iRdAddr, iMulDataValid, iMulZ,
    input  oRdData, oBusy, oDone, oError, oMulEnable, oMulLoad, oMulX, oMulY
  );
endinterface

// File: rtl/mul1024_host_bridge.sv
// mul1024_host_bridge: assembles operands from bus words, runs the multiplier handshake with timeout, serves the product as words
module mul1024_host_bridge #(
  parameter int WORD_W      = 32,
  parameter int OP_W        = 1024,
  parameter int RES_W       = 2048,
  parameter int TIMEOUT_CYC = 8191
) (
  input logic iClk,
  input logic iRstn,
  mul1024_host_bridge_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LOAD, WAIT, DONE} state_t;
  state_t            state, nextState;
  logic [15:0]       cnt;
  logic [OP_W-1:0]   x, y;
  logic [RES_W-1:0]  res;
  logic [WORD_W-1:0] rdData;
  logic              err, idle, capture, timeout;
  always_comb begin
    idle      = (state == IDLE) || (state == DONE);
    capture   = (state == WAIT) && bus.iMulDataValid;
    // cnt counts WAIT cycles already elapsed, so this fires in the TIMEOUT_CYC-th WAIT cycle
    timeout   = (state == WAIT) && !bus.iMulDataValid && (cnt == 16'(TIMEOUT_CYC - 1));
    nextState = idle ? (bus.iStart ? LOAD : state) :
                (state == LOAD) ? WAIT :
                (capture || timeout) ? DONE : WAIT;
  end
  always_ff @(posedge iClk) begin
    if (!iRstn) begin
      state  <= IDLE;
      cnt    <= '0;
      x      <= '0;
      y      <= '0;
      res    <= '0;
      rdData <= '0;
      err    <= 1'b0;
    end else begin
      state <= nextState;
      cnt   <= (state == WAIT) ? cnt + 16'd1 : '0;
      if (idle && bus.iWrite && !bus.iWrSel) x[int'(bus.iWrAddr) * WORD_W +: WORD_W] <= bus.iWrData;
      if (idle && bus.iWrite && bus.iWrSel) y[int'(bus.iWrAddr) * WORD_W +: WORD_W] <= bus.iWrData;
      if (capture) res <= bus.iMulZ;
      else if (timeout) res <= '0;
      if (idle && bus.iStart) err <= 1'b0;
      else if (timeout) err <= 1'b1;
      if (bus.iRead) rdData <= idle ? res[int'(bus.iRdAddr) * WORD_W +: WORD_W] : '0;
    end
  end
  assign bus.oBusy      = (state == LOAD) || (state == WAIT);
  assign bus.oDone      = state == DONE;
  assign bus.oError     = err;
  assign bus.oMulEnable = (state == LOAD) || (state == WAIT);
  assign bus.oMulLoad   = state == LOAD;
  assign bus.oMulX      = x;
  assign bus.oMulY      = y;
  assign bus.oRdData    = rdData;
endmodule

// File: tb/tb_mul1024_host_bridge.sv
// tb_mul1024_host_bridge: directed bench with a read-data scoreboard and a behavioural multiplier response
module tb_mul1024_host_bridge;
  logic iClk = 1'b0;
  logic iRstn = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [31:0] sbq[$];
  logic [2047:0] expRes = '0;
  logic [2047:0] z;

  mul1024_host_bridge_if bus ();
  mul1024_host_bridge #(.WORD_W(32), .OP_W(1024), .RES_W(2048), .TIMEOUT_CYC(200)) dut (
    .iClk(iClk), .iRstn(iRstn), .bus(bus)
  );

  always #5 iClk = ~iClk;

  task automatic step();
    @(posedge iClk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic sel, input int k, input logic [31:0] d);
    bus.iWrite = 1'b1; bus.iWrSel = sel; bus.iWrAddr = 5'(k); bus.iWrData = d;
    step();
    bus.iWrite = 1'b0;
  endtask

  task automatic startOp();
    bus.iStart = 1'b1;
    step();
    bus.iStart = 1'b0;
  endtask

  // called in the LOAD cycle: valid stays low for n-1 WAIT cycles and rises in WAIT cycle n
  task automatic respond(input int n, input logic [2047:0] zz);
    repeat (n) step();
    bus.iMulDataValid = 1'b1; bus.iMulZ = zz;
    step();
    bus.iMulDataValid = 1'b0; bus.iMulZ = '0;
    expRes = zz;
  endtask

  task automatic readChk(input string tag, input int k, input bit zeroExp);
    logic [31:0] e;
    sbq.push_back(zeroExp ? 32'h0 : expRes[k*32 +: 32]);
    bus.iRead = 1'b1; bus.iRdAddr = 6'(k);
    step();
    bus.iRead = 1'b0;
    e = sbq.pop_front();
    chk(tag, 64'(bus.oRdData), 64'(e));
  endtask

  initial begin
    bus.iWrite = 0; bus.iWrSel = 0; bus.iWrAddr = '0; bus.iWrData = '0; bus.iStart = 0;
    bus.iRead = 0; bus.iRdAddr = '0; bus.iMulDataValid = 0; bus.iMulZ = '0;
    step(); step();
    chk("rst busy", 64'(bus.oBusy), 0);
    chk("rst done", 64'(bus.oDone), 0);
    chk("rst enable", 64'(bus.oMulEnable), 0);
    chk("rst rddata", 64'(bus.oRdData), 0);
    iRstn = 1'b1;
    step();

    wr(0, 0, 32'd3);
    wr(1, 0, 32'd5);
    chk("t1 enable idle", 64'(bus.oMulEnable), 0);
    startOp();
    chk("t1 load", 64'(bus.oMulLoad), 1);
    chk("t1 enable load", 64'(bus.oMulEnable), 1);
    chk("t1 x0", 64'(bus.oMulX[31:0]), 3);
    chk("t1 y0", 64'(bus.oMulY[31:0]), 5);
    step();
    chk("t1 load one cycle", 64'(bus.oMulLoad), 0);
    chk("t1 busy wait", 64'(bus.oBusy), 1);
    respond(99, 2048'd15);
    chk("t1 done", 64'(bus.oDone), 1);
    chk("t1 error", 64'(bus.oError), 0);
    chk("t1 enable done", 64'(bus.oMulEnable), 0);
    readChk("t1 rd0", 0, 0);
    readChk("t1 rd1", 1, 0);
    step();
    chk("t1 rd hold", 64'(bus.oRdData), 0);

    for (int k = 0; k < 32; k++) begin
      wr(0, k, 32'hFFFF_FFFF);
      wr(1, k, 32'(k));
    end
    for (int k = 0; k < 32; k++) begin
      chk($sformatf("t2 x%0d", k), 64'(bus.oMulX[k*32 +: 32]), 64'hFFFF_FFFF);
      chk($sformatf("t2 y%0d", k), 64'(bus.oMulY[k*32 +: 32]), 64'(k));
    end
    for (int k = 0; k < 64; k++) z[k*32 +: 32] = 32'hA500_0000 + 32'(k);
    startOp();
    respond(30, z);
    for (int k = 0; k < 64; k++) readChk($sformatf("t2 rd%0d", k), k, 0);

    startOp();
    chk("t3 error cleared in load", 64'(bus.oError), 0);
    chk("t3 done cleared in load", 64'(bus.oDone), 0);
    readChk("t3 rd busy", 0, 1);
    repeat (199) step();
    chk("t3 busy at limit", 64'(bus.oBusy), 1);
    chk("t3 not done at limit", 64'(bus.oDone), 0);
    step();
    expRes = '0;
    chk("t3 timeout done", 64'(bus.oDone), 1);
    chk("t3 timeout error", 64'(bus.oError), 1);
    chk("t3 timeout enable", 64'(bus.oMulEnable), 0);
    readChk("t3 rd0 zeroed", 0, 0);
    readChk("t3 rd5 zeroed", 5, 0);
    startOp();
    chk("t3b error cleared", 64'(bus.oError), 0);
    respond(200, 2048'h1234_5678_9ABC);
    chk("t3b done", 64'(bus.oDone), 1);
    chk("t3b error", 64'(bus.oError), 0);
    readChk("t3b rd0", 0, 0);
    readChk("t3b rd1", 1, 0);

    startOp();
    repeat (5) step();
    bus.iWrite = 1'b1; bus.iWrSel = 1'b0; bus.iWrAddr = '0; bus.iWrData = 32'h9;
    bus.iStart = 1'b1;
    step();
    bus.iWrite = 1'b0; bus.iStart = 1'b0;
    chk("t4 x0 unchanged", 64'(bus.oMulX[31:0]), 64'hFFFF_FFFF);
    chk("t4 no reload", 64'(bus.oMulLoad), 0);
    step();
    chk("t4 still waiting", 64'(bus.oBusy), 1);
    chk("t4 no reload later", 64'(bus.oMulLoad), 0);
    respond(10, 2048'hBEEF);
    chk("t4 done", 64'(bus.oDone), 1);
    bus.iWrite = 1'b1; bus.iWrSel = 1'b0; bus.iWrAddr = '0; bus.iWrData = 32'h7;
    bus.iStart = 1'b1;
    step();
    bus.iWrite = 1'b0; bus.iStart = 1'b0;
    chk("t4 load with write", 64'(bus.oMulLoad), 1);
    chk("t4 x0 updated", 64'(bus.oMulX[31:0]), 7);
    respond(5, 2048'h77);
    readChk("t4 rd0", 0, 0);

    startOp();
    repeat (20) step();
    iRstn = 1'b0;
    step();
    iRstn = 1'b1;
    expRes = '0;
    chk("t5 busy", 64'(bus.oBusy), 0);
    chk("t5 done", 64'(bus.oDone), 0);
    chk("t5 error", 64'(bus.oError), 0);
    chk("t5 enable", 64'(bus.oMulEnable), 0);
    chk("t5 load", 64'(bus.oMulLoad), 0);
    chk("t5 rddata", 64'(bus.oRdData), 0);
    chk("t5 x0", 64'(bus.oMulX[31:0]), 0);
    chk("t5 y0", 64'(bus.oMulY[31:0]), 0);
    readChk("t5 rd0 cleared", 0, 0);
    wr(0, 0, 32'd3);
    wr(1, 0, 32'd5);
    startOp();
    chk("t5 restart load", 64'(bus.oMulLoad), 1);
    respond(100, 2048'd15);
    chk("t5 restart done", 64'(bus.oDone), 1);
    readChk("t5 rd0", 0, 0);

    startOp();
    bus.iMulDataValid = 1'b1; bus.iMulZ = 2048'hDEAD;
    step();
    bus.iMulDataValid = 1'b0; bus.iMulZ = '0;
    chk("t6 valid in load ignored", 64'(bus.oBusy), 1);
    respond(50, 2048'hC0FFEE);
    chk("t6 done", 64'(bus.oDone), 1);
    readChk("t6 rd0", 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
